// File: rtl/tiamc1_analog_in.sv
// rtl/tiamc1_analog_in.sv - TIA-MC1 analog input conditioning (joystick/paddle/spinner to frame-latched position)
module tiamc1_analog_in #(
  parameter logic [7:0] POS_MIN    = 8'd16,
  parameter logic [7:0] POS_MAX    = 8'd239,
  parameter logic [7:0] CENTER     = 8'd128,
  parameter int         SPIN_SHIFT = 1,
  parameter logic [7:0] DIG_STEP   = 8'd4,
  parameter logic [7:0] DEADZONE   = 8'd8
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        vblank,
  input  logic [1:0]  joy_dig,
  input  logic [15:0] joystick_analog_0,
  input  logic [7:0]  paddle_0,
  input  logic [8:0]  spinner_0,
  input  logic [2:0]  cfg_analog,
  output logic [7:0]  pos_out,
  output logic        pos_strobe,
  output logic        active
);

  localparam logic [1:0] MODE_PADDLE  = 2'd1;
  localparam logic [1:0] MODE_SPINNER = 2'd2;

  localparam logic signed [10:0] MIN_S    = {3'b000, POS_MIN};
  localparam logic signed [10:0] MAX_S    = {3'b000, POS_MAX};
  localparam logic signed [10:0] CENTER_S = {3'b000, CENTER};
  localparam logic signed [10:0] STEP_S   = {3'b000, DIG_STEP};
  localparam logic signed [10:0] DZ_S     = {3'b000, DEADZONE};

  // Reset asserts asynchronously, releases on a clock edge.
  logic [1:0] rst_sync;
  logic       rst_n_int;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n_int = rst_sync[1];

  logic [7:0] pos;
  logic [7:0] pos_next;
  logic [7:0] pos_inv;
  logic [1:0] mode_q;
  logic       vblank_q;
  logic       spin_tog_q;
  logic       started;
  logic       sticky;

  logic              vb_rise;
  logic              mode_chg;
  logic              spin_evt;
  logic              x_active;
  logic signed [10:0] x_s;
  logic signed [10:0] x_abs;
  logic signed [10:0] pos_s;
  logic signed [10:0] spin_ext;
  logic signed [10:0] spin_d;
  logic              unused_y;

  function automatic logic [7:0] clamp(input logic signed [10:0] v);
    if (v < MIN_S)      return POS_MIN;
    else if (v > MAX_S) return POS_MAX;
    else                return v[7:0];
  endfunction

  assign unused_y = ^joystick_analog_0[15:8];

  assign vb_rise  = vblank & ~vblank_q;
  assign mode_chg = cfg_analog[1:0] != mode_q;
  // The first cycle after release only captures the toggle phase.
  assign spin_evt = started & (spinner_0[8] != spin_tog_q);

  assign x_s      = {{3{joystick_analog_0[7]}}, joystick_analog_0[7:0]};
  assign x_abs    = joystick_analog_0[7] ? -x_s : x_s;
  assign x_active = x_abs >= DZ_S;
  assign pos_s    = {3'b000, pos};
  assign spin_ext = {{3{spinner_0[7]}}, spinner_0[7:0]};
  assign spin_d   = spin_ext <<< SPIN_SHIFT;
  assign pos_inv  = POS_MAX + POS_MIN - pos;

  always_comb begin
    pos_next = pos;
    if (mode_chg) begin
      pos_next = CENTER;
    end else begin
      case (mode_q)
        MODE_PADDLE: pos_next = clamp({3'b000, paddle_0});
        MODE_SPINNER: begin
          if (spin_evt) pos_next = clamp(pos_s + spin_d);
        end
        default: begin
          if (x_active) begin
            pos_next = clamp(CENTER_S + x_s);
          end else if (vb_rise) begin
            if (joy_dig == 2'b01)      pos_next = clamp(pos_s + STEP_S);
            else if (joy_dig == 2'b10) pos_next = clamp(pos_s - STEP_S);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n_int) begin
    if (!rst_n_int) begin
      pos        <= CENTER;
      pos_out    <= CENTER;
      pos_strobe <= 1'b0;
      active     <= 1'b0;
      sticky     <= 1'b0;
      spin_tog_q <= 1'b0;
      started    <= 1'b0;
      mode_q     <= 2'd0;
      vblank_q   <= 1'b0;
    end else begin
      started    <= 1'b1;
      spin_tog_q <= spinner_0[8];
      mode_q     <= cfg_analog[1:0];
      vblank_q   <= vblank;
      pos        <= pos_next;
      pos_strobe <= vb_rise;
      // Latch uses the pre-update pos; a change in this same cycle counts for the next frame.
      if (vb_rise) begin
        pos_out <= cfg_analog[2] ? pos : pos_inv;
        active  <= sticky;
        sticky  <= pos_next != pos;
      end else begin
        sticky  <= sticky | (pos_next != pos);
      end
    end
  end

endmodule

// File: tb/tb_tiamc1_analog_in.sv
// tb/tb_tiamc1_analog_in.sv - directed self-checking bench for tiamc1_analog_in
module tb_tiamc1_analog_in;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        vblank = 1'b0;
  logic [1:0]  joy_dig = 2'b00;
  logic [15:0] joystick_analog_0 = 16'h0000;
  logic [7:0]  paddle_0 = 8'd0;
  logic [8:0]  spinner_0 = 9'd0;
  logic [2:0]  cfg_analog = 3'b110;
  logic [7:0]  pos_out;
  logic        pos_strobe;
  logic        active;

  logic tog = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  tiamc1_analog_in dut (
    .clk_sys           (clk_sys),
    .reset_n           (reset_n),
    .vblank            (vblank),
    .joy_dig           (joy_dig),
    .joystick_analog_0 (joystick_analog_0),
    .paddle_0          (paddle_0),
    .spinner_0         (spinner_0),
    .cfg_analog        (cfg_analog),
    .pos_out           (pos_out),
    .pos_strobe        (pos_strobe),
    .active            (active)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic spin(input logic [7:0] d);
    tog = ~tog;
    spinner_0 = {tog, d};
    tick(1);
  endtask

  task automatic frame(input string tag, input logic [7:0] exp);
    vblank = 1'b1;
    tick(1);
    check({tag, "_pos"}, {24'd0, pos_out}, {24'd0, exp});
    check({tag, "_strobe"}, {31'd0, pos_strobe}, 32'd1);
    vblank = 1'b0;
    tick(1);
    check({tag, "_strobe_end"}, {31'd0, pos_strobe}, 32'd0);
  endtask

  initial begin
    // Reset state, spinner mode, normal axis
    tick(2);
    check("rst_pos", {24'd0, pos_out}, 32'd128);
    check("rst_strobe", {31'd0, pos_strobe}, 32'd0);
    check("rst_active", {31'd0, active}, 32'd0);
    reset_n = 1'b1;
    tick(4);
    spin(8'd5);
    spin(8'd5);
    check("midframe_hold", {24'd0, pos_out}, 32'd128);
    frame("spin2", 8'd148);
    check("spin2_active", {31'd0, active}, 32'd1);

    // Spinner saturation high then low
    for (int i = 0; i < 20; i++) spin(8'd127);
    check("sat_midframe", {24'd0, pos_out}, 32'd148);
    frame("sat_hi", 8'd239);
    spin(8'h80);
    frame("sat_lo", 8'd16);

    // Joystick analog then digital stepping
    cfg_analog = 3'b100;
    joystick_analog_0 = 16'h003C;
    tick(2);
    frame("joy60", 8'd188);
    joystick_analog_0 = 16'h0004;
    joy_dig = 2'b01;
    tick(1);
    frame("dig_r0", 8'd188);
    frame("dig_r1", 8'd192);
    frame("dig_r2", 8'd196);
    frame("dig_r3", 8'd200);
    joy_dig = 2'b11;
    frame("dig_both0", 8'd204);
    frame("dig_both1", 8'd204);
    joy_dig = 2'b00;
    joystick_analog_0 = 16'h0080;
    tick(1);
    frame("joy_m128", 8'd16);
    joystick_analog_0 = 16'h00F9;
    joy_dig = 2'b01;
    tick(1);
    frame("dz_m7_a", 8'd16);
    frame("dz_m7_b", 8'd20);
    joy_dig = 2'b00;

    // Paddle clamping and inversion
    cfg_analog = 3'b101;
    paddle_0 = 8'd0;
    tick(2);
    frame("pad0", 8'd16);
    paddle_0 = 8'd250;
    tick(1);
    frame("pad250", 8'd239);
    cfg_analog = 3'b001;
    paddle_0 = 8'd100;
    tick(1);
    frame("pad_inv", 8'd155);

    // Spinner event coincident with vblank rise
    cfg_analog = 3'b110;
    tick(2);
    spin(8'd1);
    tog = ~tog;
    spinner_0 = {tog, 8'd3};
    vblank = 1'b1;
    tick(1);
    check("coinc_pos", {24'd0, pos_out}, 32'd130);
    check("coinc_strobe", {31'd0, pos_strobe}, 32'd1);
    check("coinc_active", {31'd0, active}, 32'd1);
    vblank = 1'b0;
    tick(1);
    frame("coinc_next", 8'd136);
    check("coinc_next_active", {31'd0, active}, 32'd1);

    // Mode change mid-frame, then asynchronous reset between clocks
    cfg_analog = 3'b101;
    paddle_0 = 8'd200;
    tick(3);
    check("pre_rst_pos", {24'd0, pos_out}, 32'd136);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_pos", {24'd0, pos_out}, 32'd128);
    check("arst_strobe", {31'd0, pos_strobe}, 32'd0);
    check("arst_active", {31'd0, active}, 32'd0);
    tick(1);
    reset_n = 1'b1;
    tick(5);
    frame("post_rst", 8'd200);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
